// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings and bus slice widths for mem_arbiter.
// Priority scheme is chosen by ARB_ROUND_ROBIN_EN in the files that import this package.
package mem_arb_pkg;
  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  localparam int MAX_MASTERS = 8;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LANE_W = 4;
endpackage

// File: rtl/mem_arbiter_picker.sv
// arb_picker: combinational winner selection over the request vector.
// ARB_ROUND_ROBIN_EN: search starts after 'pointer'; otherwise the lowest index wins.
module arb_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int GW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [GW-1:0]          pointer,
`endif
  output logic [GW-1:0]          winner,
  output logic                   any
);

`ifdef ARB_ROUND_ROBIN_EN
  function automatic int rr_index(input int p, input int k);
    return (p + 1 + k) % NUM_MASTERS;
  endfunction

  // First requester found walking upward from the slot after the last winner.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!any && req[rr_index(int'(pointer), k)]) begin
        winner = GW'(rr_index(int'(pointer), k));
        any    = 1'b1;
      end
    end
  end
`else
  // Descending scan so the lowest requesting index is the last assignment.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req[k]) begin
        winner = GW'(k);
        any    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one valid/ready memory port among NUM_MASTERS masters, one transfer at a time.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default build is fixed priority (master 0 first).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int GW          = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dout,
  input  logic [NUM_MASTERS-1:0]        m_wr,
  input  logic [NUM_MASTERS*LANE_W-1:0] m_lane,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_din,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_dout,
  output logic                          s_wr,
  output logic [LANE_W-1:0]             s_lane,
  output logic                          s_valid,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_din,
  output logic                          busy,
  output logic [GW-1:0]                 grant
);

  logic          state_reg, state_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] winner;
  logic          any;

  logic [ADDR_W-1:0] addr_slice [NUM_MASTERS];
  logic [DATA_W-1:0] dout_slice [NUM_MASTERS];
  logic [LANE_W-1:0] lane_slice [NUM_MASTERS];

`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0] ptr_reg, ptr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_reg <= GW'(NUM_MASTERS - 1);
    else     ptr_reg <= ptr_next;
  end
`endif

  arb_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .GW         (GW)
  ) u_picker (
    .req    (m_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .pointer(ptr_reg),
`endif
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  // A granted master dropping valid early is treated as an abort: leave BUSY without m_ready.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_next   = ptr_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (any) begin
          state_next = S_BUSY;
          grant_next = winner;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_next   = winner;
`endif
        end
      end
      default: begin
        if ((s_valid && s_ready) || !m_valid[grant_reg]) state_next = S_IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
      assign addr_slice[gi] = m_addr[gi*ADDR_W +: ADDR_W];
      assign dout_slice[gi] = m_dout[gi*DATA_W +: DATA_W];
      assign lane_slice[gi] = m_lane[gi*LANE_W +: LANE_W];
      assign m_ready[gi]    = busy && (grant_reg == GW'(gi)) && s_ready;
    end
  endgenerate

  // The async reset clears state_reg, so s_valid falls immediately with rst.
  assign busy    = (state_reg == S_BUSY);
  assign grant   = grant_reg;
  assign s_addr  = addr_slice[grant_reg];
  assign s_dout  = dout_slice[grant_reg];
  assign s_lane  = lane_slice[grant_reg];
  assign s_wr    = m_wr[grant_reg];
  assign s_valid = busy && m_valid[grant_reg];
  assign m_din   = s_din;

endmodule
